// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter that shares one data memory between an instruction-fetch port (A)
// and a load/store port (B). Each command takes IDLE -> ACCESS -> RESP.
module mem_access_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_byte,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_done,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_byte,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_byteOperations,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_b_q, last_b_d;     // 1 = port B was granted last
    logic                owner_b_q, owner_b_d;
    logic                cmd_we_q, cmd_we_d;
    logic                cmd_byte_q, cmd_byte_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic                grant_b;
    logic [DATA_W-1:0]   read_word;

    // On a tie the port that was not served last wins.
    assign grant_b   = b_req && (!a_req || !last_b_q);
    assign read_word = cmd_byte_q ? {{(DATA_W-8){1'b0}}, mem_read_data[7:0]} : mem_read_data;

    always_comb begin
        state_d     = state_q;
        last_b_d    = last_b_q;
        owner_b_d   = owner_b_q;
        cmd_we_d    = cmd_we_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    state_d     = ACCESS;
                    owner_b_d   = grant_b;
                    last_b_d    = grant_b;
                    cmd_we_d    = grant_b ? b_we    : a_we;
                    cmd_byte_d  = grant_b ? b_byte  : a_byte;
                    cmd_addr_d  = grant_b ? b_addr  : a_addr;
                    cmd_wdata_d = grant_b ? b_wdata : a_wdata;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!cmd_we_q) begin
                    if (owner_b_q) begin
                        b_rdata_d = read_word;
                    end else begin
                        a_rdata_d = read_word;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            owner_b_q   <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_byte_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_b_q    <= last_b_d;
            owner_b_q   <= owner_b_d;
            cmd_we_q    <= cmd_we_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    // Strobes decode straight from the state so an async reset kills them at once.
    assign mem_memWrite       = (state_q == ACCESS) && cmd_we_q;
    assign mem_memRead        = (state_q == ACCESS) && !cmd_we_q;
    assign mem_address        = cmd_addr_q;
    assign mem_byteOperations = cmd_byte_q;
    assign mem_write_data     = cmd_byte_q ? {{(DATA_W-8){1'b0}}, cmd_wdata_q[7:0]} : cmd_wdata_q;
    assign a_done             = (state_q == RESP) && !owner_b_q;
    assign b_done             = (state_q == RESP) && owner_b_q;
    assign a_rdata            = a_rdata_q;
    assign b_rdata            = b_rdata_q;
    assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: memory fixture, per-cycle reference model and
// directed command sequences with hand-computed expectations.
module tb_mem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, a_byte = 1'b0;
    logic [7:0]  a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic [31:0] a_rdata;
    logic        a_done;
    logic        b_req = 1'b0, b_we = 1'b0, b_byte = 1'b0;
    logic [7:0]  b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic [31:0] b_rdata;
    logic        b_done;
    logic [7:0]  mem_address;
    logic [31:0] mem_write_data;
    logic        mem_byteOperations, mem_memRead, mem_memWrite;
    logic [31:0] mem_read_data;
    logic        busy;

    int checks = 0;
    int failures = 0;

    mem_access_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset(rst),
        .a_req(a_req), .a_we(a_we), .a_byte(a_byte), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_done(a_done),
        .b_req(b_req), .b_we(b_we), .b_byte(b_byte), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_done(b_done),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_byteOperations(mem_byteOperations), .mem_memRead(mem_memRead),
        .mem_memWrite(mem_memWrite), .mem_read_data(mem_read_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory fixture: combinational read, write on the rising edge.
    logic [31:0] tb_mem [256] = '{default: 32'h0};
    assign mem_read_data = tb_mem[mem_address];
    initial forever begin
        @(posedge clk);
        if (mem_memWrite) tb_mem[mem_address] <= mem_write_data;
    end

    // Reference model: a command is "in service" for two cycles after the grant edge;
    // m_left counts cycles remaining (2 = memory cycle, 1 = completion cycle).
    int          m_left = 0;
    bit          m_last_b = 1'b1;
    bit          m_owner_b = 1'b0, m_we = 1'b0, m_byte = 1'b0;
    logic [7:0]  m_addr = '0;
    logic [31:0] m_wdata = '0, m_ra = '0, m_rb = '0;
    logic [31:0] m_mem [256] = '{default: 32'h0};

    function automatic logic [31:0] low_byte(input logic [31:0] w);
        return w & 32'h0000_00FF;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_left = 0; m_last_b = 1'b1; m_owner_b = 1'b0; m_we = 1'b0; m_byte = 1'b0;
            m_addr = '0; m_wdata = '0; m_ra = '0; m_rb = '0;
        end else if (m_left == 0) begin
            if (a_req || b_req) begin
                m_owner_b = (a_req && b_req) ? !m_last_b : b_req;
                m_last_b  = m_owner_b;
                m_we      = m_owner_b ? b_we    : a_we;
                m_byte    = m_owner_b ? b_byte  : a_byte;
                m_addr    = m_owner_b ? b_addr  : a_addr;
                m_wdata   = m_owner_b ? b_wdata : a_wdata;
                m_left    = 2;
            end
        end else if (m_left == 2) begin
            if (m_we) m_mem[m_addr] = m_byte ? low_byte(m_wdata) : m_wdata;
            else if (m_owner_b) m_rb = m_byte ? low_byte(m_mem[m_addr]) : m_mem[m_addr];
            else m_ra = m_byte ? low_byte(m_mem[m_addr]) : m_mem[m_addr];
            m_left = 1;
        end else begin
            m_left = 0;
        end
    end

    // Per-cycle comparison against the model, plus event monitors.
    int         wr_total = 0, byte_total = 0, done_total = 0;
    logic [7:0] done_order = '0;   // shift register of dones, 1 = B
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("busy",      {31'b0, busy},         {31'b0, m_left != 0});
            chk("memWrite",  {31'b0, mem_memWrite}, {31'b0, m_left == 2 && m_we});
            chk("memRead",   {31'b0, mem_memRead},  {31'b0, m_left == 2 && !m_we});
            chk("a_done",    {31'b0, a_done},       {31'b0, m_left == 1 && !m_owner_b});
            chk("b_done",    {31'b0, b_done},       {31'b0, m_left == 1 && m_owner_b});
            chk("mem_addr",  {24'b0, mem_address},  {24'b0, m_addr});
            chk("mem_wdata", mem_write_data,        m_byte ? low_byte(m_wdata) : m_wdata);
            chk("mem_byte",  {31'b0, mem_byteOperations}, {31'b0, m_byte});
            chk("a_rdata",   a_rdata, m_ra);
            chk("b_rdata",   b_rdata, m_rb);
            if (mem_memWrite) wr_total++;
            if (mem_byteOperations && (mem_memRead || mem_memWrite)) byte_total++;
            if (a_done || b_done) begin
                done_total++;
                done_order = {done_order[6:0], b_done};
            end
        end
    end

    task automatic a_cmd(input bit we, input bit byt, input logic [7:0] addr,
                         input logic [31:0] wd, input bit drop, output int lat);
        @(posedge clk); #1;
        a_we = we; a_byte = byt; a_addr = addr; a_wdata = wd; a_req = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (a_done) begin lat = i; break; end
        end
        if (lat == 0) begin
            checks++; failures++;
            $display("FAIL a_timeout: got no a_done expected a_done within 20 cycles");
        end
        if (drop) begin @(posedge clk); #1; a_req = 1'b0; end
    endtask

    task automatic b_cmd(input bit we, input bit byt, input logic [7:0] addr,
                         input logic [31:0] wd, input bit drop, output int lat);
        @(posedge clk); #1;
        b_we = we; b_byte = byt; b_addr = addr; b_wdata = wd; b_req = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (b_done) begin lat = i; break; end
        end
        if (lat == 0) begin
            checks++; failures++;
            $display("FAIL b_timeout: got no b_done expected b_done within 20 cycles");
        end
        if (drop) begin @(posedge clk); #1; b_req = 1'b0; end
    endtask

    initial begin
        int lat, lat_a, lat_b, wr0, by0, dn0;
        bit seen;

        // Reset state, then release with no requests.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   {31'b0, busy}, 32'h0);
        chk("rst_strobe", {30'b0, mem_memRead, mem_memWrite}, 32'h0);
        chk("rst_done",   {30'b0, a_done, b_done}, 32'h0);
        chk("rst_addr",   {24'b0, mem_address}, 32'h0);
        chk("rst_wdata",  mem_write_data, 32'h0);
        chk("rst_rdata",  a_rdata | b_rdata, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy",   {31'b0, busy}, 32'h0);
        chk("idle_strobe", {29'b0, mem_memRead, mem_memWrite, mem_byteOperations}, 32'h0);
        $display("reset: busy=%0b a_rdata=%08h b_rdata=%08h", busy, a_rdata, b_rdata);

        // Word write on A, then word read on B.
        wr0 = wr_total;
        a_cmd(1'b1, 1'b0, 8'h00, 32'h1000_0002, 1'b1, lat);
        chk("t2_a_latency", lat, 32'd3);
        chk("t2_write_cycles", wr_total - wr0, 32'd1);
        $display("A wr  addr=00 data=10000002 latency=%0d", lat);
        b_cmd(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, lat);
        chk("t2_b_rdata", b_rdata, 32'h1000_0002);
        chk("t2_b_latency", lat, 32'd3);
        $display("B rd  addr=00 rdata=%08h", b_rdata);

        // Byte write then byte read on A.
        by0 = byte_total;
        a_cmd(1'b1, 1'b1, 8'h01, 32'hAABB_CC77, 1'b1, lat);
        a_cmd(1'b0, 1'b1, 8'h01, 32'h0, 1'b1, lat);
        chk("t3_a_rdata", a_rdata, 32'h0000_0077);
        chk("t3_byte_cycles", byte_total - by0, 32'd2);
        chk("t3_mem_word", tb_mem[1], 32'h0000_0077);
        $display("A rdb addr=01 rdata=%08h", a_rdata);

        // Simultaneous requests after a fresh reset, each port holding for two commands.
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        dn0 = done_total;
        fork
            begin
                a_cmd(1'b1, 1'b0, 8'h40, 32'h0000_00A1, 1'b0, lat_a);
                a_cmd(1'b1, 1'b0, 8'h41, 32'h0000_00A2, 1'b1, lat_a);
            end
            begin
                b_cmd(1'b1, 1'b0, 8'h50, 32'h0000_00B1, 1'b0, lat_b);
                b_cmd(1'b1, 1'b0, 8'h51, 32'h0000_00B2, 1'b1, lat_b);
            end
        join
        chk("t4_done_count", done_total - dn0, 32'd4);
        chk("t4_order", {28'b0, done_order[3:0]}, 32'h5);
        chk("t4_mem41", tb_mem[8'h41], 32'h0000_00A2);
        chk("t4_mem50", tb_mem[8'h50], 32'h0000_00B1);
        $display("A/B contention order=%04b", done_order[3:0]);

        // Reset pulsed during the memory cycle of a B write.
        @(posedge clk); #1;
        b_we = 1'b1; b_byte = 1'b0; b_addr = 8'h60; b_wdata = 32'h0000_DEAD; b_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_memWrite) begin seen = 1'b1; break; end
        end
        chk("t5_reached_access", {31'b0, seen}, 32'h1);
        #1; rst = 1'b1;
        #1;
        chk("t5_memWrite", {31'b0, mem_memWrite}, 32'h0);
        chk("t5_busy", {31'b0, busy}, 32'h0);
        chk("t5_b_done", {31'b0, b_done}, 32'h0);
        #1; rst = 1'b0; b_req = 1'b0;
        dn0 = done_total;
        repeat (4) @(negedge clk);
        chk("t5_no_done", done_total - dn0, 32'd0);
        $display("B wr  addr=60 aborted by reset busy=%0b", busy);

        // A changes its fields while its own write is in flight.
        @(posedge clk); #1;
        a_we = 1'b1; a_byte = 1'b0; a_addr = 8'h10; a_wdata = 32'hCAFE_F00D; a_req = 1'b1;
        @(posedge clk); #1;
        a_addr = 8'h20; a_wdata = 32'h1234_5678;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_done) begin seen = 1'b1; break; end
        end
        chk("t6_done", {31'b0, seen}, 32'h1);
        @(posedge clk); #1; a_req = 1'b0;
        chk("t6_mem10", tb_mem[8'h10], 32'hCAFE_F00D);
        chk("t6_mem20", tb_mem[8'h20], 32'h0);
        b_cmd(1'b0, 1'b0, 8'h10, 32'h0, 1'b1, lat);
        chk("t6_b_rdata", b_rdata, 32'hCAFE_F00D);
        $display("A wr  addr=10 (fields moved mid-flight) readback=%08h", b_rdata);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
